// File: rtl/reorder_buffer.sv
// reorder_buffer
//   Circular reorder buffer of DEPTH entries. The entry index doubles as the
//   physical register number. Entries are allocated in order at the tail,
//   completed out of order by writeback, and retired in order from the head.
//
//   Optional feature macro: ROB_FLUSH_EN adds the flush port, which discards
//   every entry.
//
// Ports
//   clock, reset        single clock, synchronous active-high reset
//   flush               discard all entries (only with ROB_FLUSH_EN)
//   alloc_arf/alloc_pc  destination and address of the instruction being allocated
//   do_alloc            allocate request
//   next_free           tail index, zero-extended to 8 bits
//   is_free             at least one entry free
//   wb_valid/wb_prf     writeback strobe and target entry
//   wb_result/wb_flags  writeback payload
//   commit_*            head entry contents; commit_valid = head retires this cycle
module reorder_buffer #(
  parameter int unsigned DEPTH = 32
) (
  input  logic        clock,
  input  logic        reset,
`ifdef ROB_FLUSH_EN
  input  logic        flush,
`endif
  input  logic [4:0]  alloc_arf,
  input  logic [63:0] alloc_pc,
  input  logic        do_alloc,
  output logic [7:0]  next_free,
  output logic        is_free,
  input  logic        wb_valid,
  input  logic [7:0]  wb_prf,
  input  logic [63:0] wb_result,
  input  logic [12:0] wb_flags,
  output logic [4:0]  commit_arf,
  output logic [7:0]  commit_prf,
  output logic [63:0] commit_result,
  output logic [63:0] commit_pc,
  output logic [12:0] commit_flags,
  output logic        commit_valid
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL   = (AW+1)'(DEPTH);
  localparam logic [8:0]  DEPTH9 = 9'(DEPTH);
  localparam logic [AW-1:0] ONE  = AW'(1);

  logic [4:0]  arf_q    [DEPTH];
  logic [63:0] pc_q     [DEPTH];
  logic [63:0] result_q [DEPTH];
  logic [12:0] flags_q  [DEPTH];

  logic [AW-1:0]    head_q, head_d, tail_q, tail_d;
  logic [AW:0]      count_q, count_d;
  logic [DEPTH-1:0] done_q, done_d;

  logic          kill;
  logic          alloc_ok, wb_ok;
  logic [AW-1:0] wb_idx, wb_off;

`ifdef ROB_FLUSH_EN
  assign kill = flush;
`else
  assign kill = 1'b0;
`endif

  assign is_free   = (count_q != FULL);
  assign next_free = 8'(tail_q);

  // An entry is occupied when its distance from head (mod DEPTH) is below
  // count; this stays correct across pointer wrap and when full.
  assign wb_idx = wb_prf[AW-1:0];
  assign wb_off = wb_idx - head_q;
  assign wb_ok  = wb_valid && ({1'b0, wb_prf} < DEPTH9) &&
                  ({1'b0, wb_off} < count_q) && !kill;

  assign alloc_ok     = do_alloc && is_free && !kill;
  assign commit_valid = (count_q != '0) && done_q[head_q] && !kill;

  assign commit_arf    = arf_q[head_q];
  assign commit_prf    = 8'(head_q);
  assign commit_result = result_q[head_q];
  assign commit_pc     = pc_q[head_q];
  assign commit_flags  = flags_q[head_q];

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    done_d  = done_q;
    if (kill) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      done_d  = '0;
    end else begin
      if (alloc_ok) begin
        tail_d         = tail_q + ONE;
        done_d[tail_q] = 1'b0;
      end
      if (wb_ok) begin
        done_d[wb_idx] = 1'b1;
      end
      if (commit_valid) begin
        head_d = head_q + ONE;
      end
      case ({alloc_ok, commit_valid})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      done_q  <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      done_q  <= done_d;
    end
  end

  // Payload storage is never reset; occupancy and done bits gate its use.
  always_ff @(posedge clock) begin
    if (!reset) begin
      if (alloc_ok) begin
        arf_q[tail_q] <= alloc_arf;
        pc_q[tail_q]  <= alloc_pc;
      end
      if (wb_ok) begin
        result_q[wb_idx] <= wb_result;
        flags_q[wb_idx]  <= wb_flags;
      end
    end
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// tb_reorder_buffer
//   Scoreboard bench for reorder_buffer (DEPTH = 32). Stimulus keeps a model
//   of allocated entries (order queue plus per-entry payload); a monitor pops
//   the queue and compares every retiring head entry. Directed checks cover
//   pointer, fullness and timing behaviour. Flush tests run when ROB_FLUSH_EN
//   is defined.
module tb_reorder_buffer;

  localparam int unsigned DEPTH = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
`ifdef ROB_FLUSH_EN
  logic        flush = 1'b0;
`endif
  logic [4:0]  alloc_arf = '0;
  logic [63:0] alloc_pc = '0;
  logic        do_alloc = 1'b0;
  logic [7:0]  next_free;
  logic        is_free;
  logic        wb_valid = 1'b0;
  logic [7:0]  wb_prf = '0;
  logic [63:0] wb_result = '0;
  logic [12:0] wb_flags = '0;
  logic [4:0]  commit_arf;
  logic [7:0]  commit_prf;
  logic [63:0] commit_result;
  logic [63:0] commit_pc;
  logic [12:0] commit_flags;
  logic        commit_valid;

  reorder_buffer #(.DEPTH(DEPTH)) dut (
    .clock(clock),
    .reset(reset),
`ifdef ROB_FLUSH_EN
    .flush(flush),
`endif
    .alloc_arf(alloc_arf),
    .alloc_pc(alloc_pc),
    .do_alloc(do_alloc),
    .next_free(next_free),
    .is_free(is_free),
    .wb_valid(wb_valid),
    .wb_prf(wb_prf),
    .wb_result(wb_result),
    .wb_flags(wb_flags),
    .commit_arf(commit_arf),
    .commit_prf(commit_prf),
    .commit_result(commit_result),
    .commit_pc(commit_pc),
    .commit_flags(commit_flags),
    .commit_valid(commit_valid)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;

  int          order_q[$];
  int          mtail = 0;
  logic [4:0]  m_arf [DEPTH];
  logic [63:0] m_pc  [DEPTH];
  logic [63:0] m_res [DEPTH];
  logic [12:0] m_flg [DEPTH];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One clock cycle of stimulus; the model mirrors what the buffer should accept.
  task automatic cyc(input bit al, input logic [4:0] a, input logic [63:0] pc,
                     input bit wb, input logic [7:0] p, input logic [63:0] r,
                     input logic [12:0] f);
    do_alloc  = al;
    alloc_arf = a;
    alloc_pc  = pc;
    wb_valid  = wb;
    wb_prf    = p;
    wb_result = r;
    wb_flags  = f;
    if (wb) begin
      foreach (order_q[i]) begin
        if (order_q[i] == int'(p)) begin
          m_res[p] = r;
          m_flg[p] = f;
        end
      end
    end
    if (al && order_q.size() < DEPTH) begin
      m_arf[mtail] = a;
      m_pc[mtail]  = pc;
      order_q.push_back(mtail);
      mtail = (mtail + 1) % DEPTH;
    end
    step();
  endtask

  task automatic idle();
    cyc(1'b0, '0, '0, 1'b0, '0, '0, '0);
  endtask

  task automatic do_reset();
    reset    = 1'b1;
    do_alloc = 1'b0;
    wb_valid = 1'b0;
    order_q.delete();
    mtail = 0;
    step();
    reset = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 64 && order_q.size() != 0; i++) idle();
    chk("drain_empty", 64'(order_q.size()), 0);
    chk("drain_commit_valid", commit_valid, 0);
  endtask

  // Monitor: every retiring head entry must match the oldest modelled entry.
  always @(negedge clock) begin : monitor
    int p;
    if (!reset && commit_valid) begin
      if (order_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_commit prf=%0d expected no commit at %0t", commit_prf, $time);
      end else begin
        p = order_q.pop_front();
        chk("commit_prf", commit_prf, 64'(p));
        chk("commit_arf", commit_arf, m_arf[p]);
        chk("commit_pc", commit_pc, m_pc[p]);
        chk("commit_result", commit_result, m_res[p]);
        chk("commit_flags", commit_flags, m_flg[p]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int prev;
    do_reset();
    chk("rst_next_free", next_free, 0);
    chk("rst_is_free", is_free, 1);
    chk("rst_commit_valid", commit_valid, 0);

    // Three allocates, tail advances 1, 2, 3.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 5'(i + 1), 64'h1000 + 64'(4 * i), 1'b0, '0, '0, '0);
      chk("alloc_next_free", next_free, 64'(i + 1));
    end
    idle();
    chk("alloc3_commit_valid", commit_valid, 0);
    chk("alloc3_is_free", is_free, 1);

    // Out-of-range writeback aliasing entry 0 must be ignored.
    cyc(1'b0, '0, '0, 1'b1, 8'd32, 64'hBAD, 13'h1FFF);
    chk("wb_oob_ignored", commit_valid, 0);
    cyc(1'b0, '0, '0, 1'b1, 8'd1, 64'hFEDC_BA98_7654_3210, 13'h005);
    chk("wb1_no_commit", commit_valid, 0);
    cyc(1'b0, '0, '0, 1'b1, 8'd0, 64'h0123_4567_89AB_CDEF, 13'h1A5);
    chk("wb0_commit_valid", commit_valid, 1);
    chk("wb0_commit_prf", commit_prf, 0);
    chk("wb0_commit_result", commit_result, 64'h0123_4567_89AB_CDEF);
    idle();
    chk("e1_commit_valid", commit_valid, 1);
    chk("e1_commit_prf", commit_prf, 1);
    chk("e1_commit_result", commit_result, 64'hFEDC_BA98_7654_3210);
    idle();
    chk("e2_not_done", commit_valid, 0);

    // Reset with entry 2 still in flight.
    do_reset();
    chk("rst2_commit_valid", commit_valid, 0);
    chk("rst2_next_free", next_free, 0);
    chk("rst2_is_free", is_free, 1);

    // Fill to DEPTH, then an extra allocate is ignored.
    for (int i = 0; i < DEPTH; i++)
      cyc(1'b1, 5'(i), 64'h2000 + 64'(4 * i), 1'b0, '0, '0, '0);
    chk("full_is_free", is_free, 0);
    chk("full_next_free", next_free, 0);
    cyc(1'b1, 5'd31, 64'hDEAD, 1'b0, '0, '0, '0);
    chk("over_is_free", is_free, 0);
    chk("over_next_free", next_free, 0);

    // Full with head done: commit happens, allocate is rejected.
    cyc(1'b0, '0, '0, 1'b1, 8'd0, 64'h5555_0000_0000_0000, 13'h011);
    chk("full_head_done", commit_valid, 1);
    cyc(1'b1, 5'd7, 64'h3000, 1'b0, '0, '0, '0);
    chk("full_commit_rej_nf", next_free, 0);
    chk("full_commit_rej_free", is_free, 1);
    cyc(1'b1, 5'd8, 64'h3004, 1'b0, '0, '0, '0);
    chk("refill_next_free", next_free, 1);
    chk("refill_is_free", is_free, 0);

    // Steady state: five entries, allocate and commit every cycle.
    do_reset();
    for (int i = 0; i < 5; i++)
      cyc(1'b1, 5'(i + 10), 64'h4000 + 64'(4 * i), 1'b0, '0, '0, '0);
    for (int i = 4; i >= 1; i--) begin
      cyc(1'b0, '0, '0, 1'b1, 8'(i), 64'hB0B0_0000_0000_0000 + 64'(i), 13'(i));
      chk("ss_setup_hold", commit_valid, 0);
    end
    cyc(1'b0, '0, '0, 1'b1, 8'd0, 64'hB0B0_0000_0000_0000, 13'h0);
    chk("ss_setup_ready", commit_valid, 1);
    prev = -1;
    for (int k = 0; k < 40; k++) begin
      int idx;
      idx = mtail;
      cyc(1'b1, 5'((k + 5) % 32), 64'h5000 + 64'(4 * k), prev >= 0, 8'(prev),
          64'hA5A5_0000_0000_0000 | 64'(prev), 13'(k));
      prev = idx;
      chk("ss_commit_valid", commit_valid, 1);
      chk("ss_is_free", is_free, 1);
      chk("ss_next_free", next_free, 64'(mtail));
      chk("ss_occupancy", (next_free - commit_prf) & 8'h1F, 5);
    end
    cyc(1'b0, '0, '0, 1'b1, 8'(prev), 64'hA5A5_0000_0000_0000 | 64'(prev), 13'h1);
    drain();

`ifdef ROB_FLUSH_EN
    // Flush with four entries occupied, head done.
    do_reset();
    for (int i = 0; i < 4; i++)
      cyc(1'b1, 5'(i + 20), 64'h6000 + 64'(4 * i), 1'b0, '0, '0, '0);
    cyc(1'b0, '0, '0, 1'b1, 8'd1, 64'h11, 13'h1);
    cyc(1'b0, '0, '0, 1'b1, 8'd3, 64'h33, 13'h3);
    cyc(1'b0, '0, '0, 1'b1, 8'd0, 64'h00, 13'h0);
    chk("pre_flush_valid", commit_valid, 1);
    flush    = 1'b1;
    do_alloc = 1'b1;
    wb_valid = 1'b1;
    wb_prf   = 8'd2;
    order_q.delete();
    mtail = 0;
    #1;
    chk("flush_cycle_valid", commit_valid, 0);
    step();
    flush = 1'b0;
    chk("post_flush_next_free", next_free, 0);
    chk("post_flush_is_free", is_free, 1);
    chk("post_flush_valid", commit_valid, 0);
    cyc(1'b0, '0, '0, 1'b1, 8'd2, 64'h22, 13'h2);
    chk("stale_wb_valid", commit_valid, 0);
    chk("stale_wb_next_free", next_free, 0);
    cyc(1'b1, 5'd9, 64'h7000, 1'b0, '0, '0, '0);
    cyc(1'b0, '0, '0, 1'b1, 8'd0, 64'h7777, 13'h7);
    chk("post_flush_commit", commit_valid, 1);
    drain();
`endif

    do_alloc = 1'b0;
    wb_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
